// File: rtl/mmio_bus.sv
// mmio_bus: CPU data-port fabric over data RAM, dual-port screen RAM, keyboard FIFO and registers.
// Optional 32-bit cycle timer is built only when MMIO_TIMER_EN is defined.
module mmio_bus #(
    parameter int DMEM_AW  = 10,
    parameter int SMEM_AW  = 11,
    parameter int CHAR_W   = 8,
    parameter int KFIFO_AW = 3,
    parameter int LED_W    = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               dmem_write,
    input  logic               dmem_read,
    input  logic [31:0]        dmem_addr,
    input  logic [31:0]        dmem_writedata,
    output logic [31:0]        dmem_readdata,
    input  logic [SMEM_AW-1:0] screenaddr,
    output logic [CHAR_W-1:0]  charcode,
    input  logic [15:0]        kchar,
    input  logic               kvalid,
    output logic [LED_W-1:0]   leds
);
    localparam int KDEPTH = 2 ** KFIFO_AW;

    logic [31:0]         dmem [0:2**DMEM_AW-1];
    logic [CHAR_W-1:0]   smem [0:2**SMEM_AW-1];
    logic [15:0]         kbuf [0:KDEPTH-1];
    logic [1:0]          region;
    logic [2:0]          sel;
    logic [DMEM_AW-1:0]  didx;
    logic [SMEM_AW-1:0]  sidx;
    logic [KFIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [KFIFO_AW:0]   count;
    logic                ovf, empty, full, push, pop, reg_wr;
    logic [31:0]         status, reg_rdata, timer;
    logic                unused_bits;

    assign region      = dmem_addr[14:13];
    assign sel         = dmem_addr[4:2];
    assign didx        = dmem_addr[DMEM_AW+1:2];
    assign sidx        = dmem_addr[SMEM_AW+1:2];
    assign reg_wr      = dmem_write && region == 2'b11;
    assign unused_bits = ^dmem_addr;

    assign empty  = count == '0;
    assign full   = count == (KFIFO_AW+1)'(KDEPTH);
    assign pop    = dmem_read && region == 2'b11 && sel == 3'd0 && !empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign push   = kvalid && (!full || pop);
    assign status = {29'(count), ovf, full, empty};

    always_ff @(posedge clock) begin
        if (dmem_write && region == 2'b01) dmem[didx] <= dmem_writedata;
        if (dmem_write && region == 2'b10) smem[sidx] <= dmem_writedata[CHAR_W-1:0];
        if (push) kbuf[wr_ptr] <= kchar;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            charcode <= '0;
            leds     <= '0;
        end else begin
            charcode <= smem[screenaddr];
            if (reg_wr && sel == 3'd3) leds <= dmem_writedata[LED_W-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + KFIFO_AW'(push);
            rd_ptr <= rd_ptr + KFIFO_AW'(pop);
            count  <= count + (KFIFO_AW+1)'(push) - (KFIFO_AW+1)'(pop);
            // setting beats a same-cycle clearing write
            ovf    <= (kvalid && full && !pop) || (ovf && !(reg_wr && sel == 3'd1));
        end
    end

`ifdef MMIO_TIMER_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) timer <= '0;
        else timer <= (reg_wr && sel == 3'd2) ? dmem_writedata : timer + 32'd1;
    end
`else
    assign timer = '0;
`endif

    always_comb begin
        reg_rdata = sel == 3'd0 ? (empty ? 32'd0 : {16'b0, kbuf[rd_ptr]}) :
                    sel == 3'd1 ? status :
                    sel == 3'd2 ? timer :
                    sel == 3'd3 ? 32'(leds) : 32'd0;
        dmem_readdata = region == 2'b01 ? dmem[didx] :
                        region == 2'b10 ? 32'(smem[sidx]) :
                        region == 2'b11 ? reg_rdata : 32'd0;
    end
endmodule

// File: tb/tb_mmio_bus.sv
// tb_mmio_bus: directed vector table plus hand sequences for screen, reset and timer behaviour.
module tb_mmio_bus;
    logic        clock = 0, reset = 1;
    logic        dmem_write = 0, dmem_read = 0, kvalid = 0;
    logic [31:0] dmem_addr = 0, dmem_writedata = 0, dmem_readdata;
    logic [10:0] screenaddr = 11'd5;
    logic [7:0]  charcode;
    logic [15:0] kchar = 0, leds;
    int          n_cmp = 0, n_err = 0;

    typedef struct {
        string       name;
        logic        we, re;
        logic [31:0] addr, wd;
        logic        kv;
        logic [15:0] kc;
        logic        chk;
        logic [31:0] exp;
    } vec_t;
    vec_t vq[$];

    mmio_bus dut (
        .clock(clock), .reset(reset), .dmem_write(dmem_write), .dmem_read(dmem_read),
        .dmem_addr(dmem_addr), .dmem_writedata(dmem_writedata), .dmem_readdata(dmem_readdata),
        .screenaddr(screenaddr), .charcode(charcode), .kchar(kchar), .kvalid(kvalid), .leds(leds)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic we, input logic re, input logic [31:0] addr,
                       input logic [31:0] wd, input logic kv, input logic [15:0] kc,
                       input logic c, input logic [31:0] exp);
        vec_t v;
        v.name = nm; v.we = we; v.re = re; v.addr = addr; v.wd = wd;
        v.kv = kv; v.kc = kc; v.chk = c; v.exp = exp;
        vq.push_back(v);
    endtask

    function automatic logic [31:0] st(input int cnt, input logic o);
        return (32'(cnt) << 3) | {29'd0, o, cnt == 8, cnt == 0};
    endfunction

    task automatic drive(input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] wd, input logic kv, input logic [15:0] kc);
        dmem_write = we; dmem_read = re; dmem_addr = addr;
        dmem_writedata = wd; kvalid = kv; kchar = kc;
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    initial begin
        add("st2008", 1, 0, 32'h2008, 32'h12345678, 0, 0, 0, 0);
        add("st2004", 1, 0, 32'h2004, 32'hDEADBEEF, 0, 0, 0, 0);
        add("ld2004", 0, 1, 32'h2004, 0, 0, 0, 1, 32'hDEADBEEF);
        add("ld0004", 0, 1, 32'h0004, 0, 0, 0, 1, 0);
        add("ld2008", 0, 1, 32'h2008, 0, 0, 0, 1, 32'h12345678);
        add("unmap_st", 1, 0, 32'h0010, 32'hFFFFFFFF, 0, 0, 0, 0);
        add("unmap_ld", 0, 1, 32'h0010, 0, 0, 0, 1, 0);
        add("scr_st", 1, 0, 32'h4014, 32'hFFFFFF41, 0, 0, 0, 0);
        add("scr_ld", 0, 1, 32'h4014, 0, 0, 0, 1, 32'h41);
        add("led_st", 1, 0, 32'h600C, 32'hFFFFA5A5, 0, 0, 0, 0);
        add("led_ld", 0, 1, 32'h600C, 0, 0, 0, 1, 32'hA5A5);
        add("reg4_st", 1, 0, 32'h6010, 32'hFFFFFFFF, 0, 0, 0, 0);
        add("reg4_ld", 0, 1, 32'h6010, 0, 0, 0, 1, 0);
        add("kd_empty", 0, 1, 32'h6000, 0, 0, 0, 1, 0);
        add("st_empty", 0, 1, 32'h6004, 0, 0, 0, 1, st(0, 0));
        add("push1C", 0, 0, 32'h6004, 0, 1, 16'h1C, 1, st(0, 0));
        add("push32", 0, 0, 32'h6004, 0, 1, 16'h32, 1, st(1, 0));
        add("push21", 0, 0, 32'h6004, 0, 1, 16'h21, 1, st(2, 0));
        add("st3", 0, 0, 32'h6004, 0, 0, 0, 1, 32'h18);
        add("peek", 0, 0, 32'h6000, 0, 0, 0, 1, 32'h1C);
        add("pop1", 0, 1, 32'h6000, 0, 0, 0, 1, 32'h1C);
        add("pop2", 0, 1, 32'h6000, 0, 0, 0, 1, 32'h32);
        add("pop3", 0, 1, 32'h6000, 0, 0, 0, 1, 32'h21);
        add("pop4", 0, 1, 32'h6000, 0, 0, 0, 1, 0);
        add("st_drained", 0, 0, 32'h6004, 0, 0, 0, 1, 32'h1);
        for (int i = 0; i < 9; i++)
            add("ovf_push", 0, 0, 32'h6004, 0, 1, 16'(16'h10 + i), 1, st(i, 0));
        add("st_full", 0, 0, 32'h6004, 0, 0, 0, 1, 32'h46);
        add("ovf_wr_set", 1, 0, 32'h6004, 0, 1, 16'h99, 1, 32'h46);
        add("st_ovf_kept", 0, 0, 32'h6004, 0, 0, 0, 1, 32'h46);
        add("ovf_clr", 1, 0, 32'h6004, 0, 0, 0, 1, 32'h46);
        add("st_clr", 0, 0, 32'h6004, 0, 0, 0, 1, 32'h42);
        add("full_pp", 0, 1, 32'h6000, 0, 1, 16'h20, 1, 32'h10);
        add("st_pp", 0, 0, 32'h6004, 0, 0, 0, 1, 32'h42);
        for (int i = 1; i < 8; i++)
            add("drain", 0, 1, 32'h6000, 0, 0, 0, 1, 32'(8'h10 + i));
        add("drain_last", 0, 1, 32'h6000, 0, 0, 0, 1, 32'h20);
        add("st_empty2", 0, 0, 32'h6004, 0, 0, 0, 1, 32'h1);
        add("empty_pp", 0, 1, 32'h6000, 0, 1, 16'h55, 1, 0);
        add("st_one", 0, 0, 32'h6004, 0, 0, 0, 1, st(1, 0));
        add("pop55", 0, 1, 32'h6000, 0, 0, 0, 1, 32'h55);
        add("st_empty3", 0, 0, 32'h6004, 0, 0, 0, 1, 32'h1);

        // power-on reset
        #1;
        chk("rst_leds", 32'(leds), 0);
        chk("rst_charcode", 32'(charcode), 0);
        dmem_addr = 32'h6004;
        #1;
        chk("rst_status", dmem_readdata, 32'h1);
        step; step;
        reset = 0;
        step;

        foreach (vq[i]) begin
            drive(vq[i].we, vq[i].re, vq[i].addr, vq[i].wd, vq[i].kv, vq[i].kc);
            @(negedge clock);
            if (vq[i].chk) chk(vq[i].name, dmem_readdata, vq[i].exp);
            step;
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("leds_port", 32'(leds), 32'hA5A5);
        chk("charcode_41", 32'(charcode), 32'h41);

        // display read of an index being written shows old data for one cycle
        drive(1, 0, 32'h4014, 32'h7A, 0, 0);
        @(negedge clock);
        chk("scr_same_pre", 32'(charcode), 32'h41);
        step;
        drive(0, 0, 0, 0, 0, 0);
        chk("scr_same_old", 32'(charcode), 32'h41);
        step;
        chk("scr_same_new", 32'(charcode), 32'h7A);

        // reset between edges with data queued
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1, 16'(16'h60 + i));
            step;
        end
        drive(0, 0, 32'h6004, 0, 0, 0);
        @(negedge clock);
        chk("pre_rst_status", dmem_readdata, 32'h18);
        #2;
        reset = 1;
        #1;
        chk("mid_rst_leds", 32'(leds), 0);
        chk("mid_rst_charcode", 32'(charcode), 0);
        chk("mid_rst_status", dmem_readdata, 32'h1);
        dmem_addr = 32'h2004;
        #1;
        chk("mid_rst_dram", dmem_readdata, 32'hDEADBEEF);
        step; step;
        reset = 0;
        dmem_addr = 32'h6004;
        @(negedge clock);
        chk("post_rst_status", dmem_readdata, 32'h1);
        chk("post_rst_leds", 32'(leds), 0);
        step;
        chk("post_rst_charcode", 32'(charcode), 32'h7A);

        // timer wrap
        drive(1, 0, 32'h6008, 32'hFFFFFFFE, 0, 0);
        step;
        drive(0, 1, 32'h6008, 0, 0, 0);
`ifdef MMIO_TIMER_EN
        chk("timer0", dmem_readdata, 32'hFFFFFFFE);
        step;
        chk("timer1", dmem_readdata, 32'hFFFFFFFF);
        step;
        chk("timer2", dmem_readdata, 32'h0);
`else
        for (int i = 0; i < 3; i++) begin
            chk("timer_off", dmem_readdata, 0);
            step;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
